// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register addresses, exception codes and Cause field positions
package cp0_pkg;
  localparam logic [4:0] CP0_CAUSE = 5'd12;
  localparam logic [4:0] CP0_STATUS = 5'd13;
  localparam logic [4:0] CP0_EPC = 5'd14;
  localparam int EXC_INT = 0;
  localparam int EXC_SYS = 1;
  localparam int EXC_UNIMPL = 2;
  localparam int EXC_OV = 3;
  localparam int CAUSE_CODE_LSB = 2;
  localparam int CAUSE_OVF = 31;
endpackage

// File: rtl/cp0_epc_stack.sv
// cp0_epc_stack: LIFO of saved EPCs (push_i/pop_i/d_i in; q_o top, cnt_o, full_o, empty_o out)
module cp0_epc_stack #(
  parameter int DEPTH = 4,
  parameter int DW = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DW-1:0]              d_i,
  output logic [DW-1:0]              q_o,
  output logic [$clog2(DEPTH+1)-1:0] cnt_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  logic [DW-1:0] r_mem [DEPTH];
  logic [CNTW-1:0] r_cnt;
  logic [IW-1:0] w_wi, w_ri;
  assign w_wi = IW'(r_cnt);
  assign w_ri = w_wi - 1'b1;
  assign q_o = r_mem[w_ri];
  assign cnt_o = r_cnt;
  assign full_o = r_cnt == CNTW'(DEPTH);
  assign empty_o = r_cnt == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (push_i && !full_o) begin
      r_mem[w_wi] <= d_i;
      r_cnt <= r_cnt + 1'b1;
    end else if (pop_i && !empty_o) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/cp0_nested_exc.sv
// cp0_nested_exc: CP0 with priority exception accept, Cause/Status/EPC regs, nested EPC stack, mfc0/mtc0 access
module cp0_nested_exc
  import cp0_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int STACK_DEPTH = 4,
  parameter int DW = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_SRC-1:0]               exc_req_i,
  input  logic [NUM_SRC*DW-1:0]            exc_pc_i,
  input  logic                             eret_i,
  input  logic                             mtc0_we_i,
  input  logic [4:0]                       wa_i,
  input  logic [4:0]                       ra_i,
  input  logic [DW-1:0]                    wd_i,
  output logic                             exc_taken_o,
  output logic [$clog2(NUM_SRC)-1:0]       exc_code_o,
  output logic [DW-1:0]                    cause_o,
  output logic [DW-1:0]                    status_o,
  output logic [DW-1:0]                    epc_o,
  output logic [DW-1:0]                    rd_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth_o,
  output logic                             overflow_o
);
  localparam int CW = $clog2(NUM_SRC);
  localparam logic [DW-1:0] RST_STATUS = {{(DW-NUM_SRC){1'b0}}, {NUM_SRC{1'b1}}};
  logic [DW-1:0] r_cause, r_status, r_epc, w_top, w_pc;
  logic [NUM_SRC-1:0] w_elig;
  logic [CW-1:0] w_code;
  logic w_any, w_full, w_empty, w_acc, w_ovf, w_wr, w_pop;
  assign w_elig = exc_req_i & r_status[NUM_SRC-1:0];
  always_comb begin
    w_code = '0;
    for (int k = 0; k < NUM_SRC; k++) w_code = w_elig[k] ? CW'(k) : w_code;
  end
  assign w_any = |w_elig;
  assign w_acc = w_any & ~w_full;
  assign w_ovf = w_any & w_full;
  assign w_wr = mtc0_we_i & ~w_acc;
  assign w_pop = eret_i & ~w_acc & ~mtc0_we_i & ~w_empty;
  assign w_pc = exc_pc_i[w_code*DW +: DW];
  cp0_epc_stack #(.DEPTH(STACK_DEPTH), .DW(DW)) u_stack (
    .clk(clk), .rst(rst), .push_i(w_acc), .pop_i(w_pop), .d_i(r_epc),
    .q_o(w_top), .cnt_o(depth_o), .full_o(w_full), .empty_o(w_empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cause <= '0;
      r_status <= RST_STATUS;
      r_epc <= '0;
    end else if (w_acc) begin
      r_cause[CAUSE_CODE_LSB +: CW] <= w_code;
      r_status <= r_status << NUM_SRC;
      r_epc <= w_pc - DW'(4);
    end else begin
      if (w_wr && wa_i == CP0_CAUSE) r_cause <= wd_i;
      if (w_wr && wa_i == CP0_STATUS) r_status <= wd_i;
      if (w_wr && wa_i == CP0_EPC) r_epc <= wd_i;
      if (w_pop) begin
        r_status <= r_status >> NUM_SRC;
        r_epc <= w_top;
      end
      if (w_ovf) r_cause[CAUSE_OVF] <= 1'b1;
    end
  end
  assign exc_taken_o = w_acc;
  assign exc_code_o = w_code;
  assign cause_o = r_cause;
  assign status_o = r_status;
  assign epc_o = r_epc;
  assign overflow_o = r_cause[CAUSE_OVF];
  assign rd_o = ra_i == CP0_CAUSE ? r_cause : ra_i == CP0_STATUS ? r_status : ra_i == CP0_EPC ? r_epc : '0;
endmodule

// File: tb/tb_cp0_nested_exc.sv
// tb_cp0_nested_exc: directed and randomized checks of cp0_nested_exc against a queue-based model
module tb_cp0_nested_exc;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] exc_req_i = '0;
  logic [127:0] exc_pc_i = '0;
  logic eret_i = 1'b0, mtc0_we_i = 1'b0;
  logic [4:0] wa_i = '0, ra_i = '0;
  logic [31:0] wd_i = '0;
  logic exc_taken_o, overflow_o;
  logic [1:0] exc_code_o;
  logic [31:0] cause_o, status_o, epc_o, rd_o;
  logic [2:0] depth_o;
  int n_tests = 0, n_fail = 0;
  logic [31:0] m_cause, m_status, m_epc;
  logic [31:0] stk[$];
  always #5 clk = ~clk;
  cp0_nested_exc dut (
    .clk(clk), .rst(rst), .exc_req_i(exc_req_i), .exc_pc_i(exc_pc_i), .eret_i(eret_i),
    .mtc0_we_i(mtc0_we_i), .wa_i(wa_i), .ra_i(ra_i), .wd_i(wd_i), .exc_taken_o(exc_taken_o),
    .exc_code_o(exc_code_o), .cause_o(cause_o), .status_o(status_o), .epc_o(epc_o),
    .rd_o(rd_o), .depth_o(depth_o), .overflow_o(overflow_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] mk(input logic [31:0] p0, p1, p2, p3);
    return {p3, p2, p1, p0};
  endfunction
  task automatic step(input logic r, input logic [3:0] req, input logic [127:0] pcs, input logic er,
                      input logic we, input logic [4:0] wa, input logic [4:0] ra, input logic [31:0] wd);
    int win;
    logic acc;
    logic [31:0] exp_rd;
    rst = r; exc_req_i = req; exc_pc_i = pcs; eret_i = er; mtc0_we_i = we; wa_i = wa; ra_i = ra; wd_i = wd;
    #4;
    win = -1;
    for (int k = 0; k < 4; k++) if (req[k] && m_status[k]) win = k;
    acc = win >= 0 && stk.size() < 4;
    exp_rd = ra == 5'd12 ? m_cause : ra == 5'd13 ? m_status : ra == 5'd14 ? m_epc : 32'h0;
    chk("taken", {31'b0, exc_taken_o}, {31'b0, acc});
    if (acc) chk("code", {30'b0, exc_code_o}, win);
    chk("rd", rd_o, exp_rd);
    @(posedge clk);
    #1;
    if (r) begin
      m_cause = 0; m_status = 32'hF; m_epc = 0; stk.delete();
    end else if (acc) begin
      stk.push_back(m_epc);
      m_cause[3:2] = win[1:0];
      m_status = m_status << 4;
      m_epc = pcs[win*32 +: 32] - 32'd4;
    end else begin
      if (we && wa == 5'd12) m_cause = wd;
      else if (we && wa == 5'd13) m_status = wd;
      else if (we && wa == 5'd14) m_epc = wd;
      else if (!we && er && stk.size() > 0) begin
        m_status = m_status >> 4;
        m_epc = stk.pop_back();
      end
      if (win >= 0) m_cause[31] = 1'b1;
    end
    chk("cause", cause_o, m_cause);
    chk("status", status_o, m_status);
    chk("epc", epc_o, m_epc);
    chk("depth", {29'b0, depth_o}, stk.size());
    chk("ovf", {31'b0, overflow_o}, {31'b0, m_cause[31]});
  endtask
  task automatic idle(input logic [4:0] ra); step(0, 0, 0, 0, 0, 0, ra, 0); endtask
  task automatic wr(input logic [4:0] wa, input logic [31:0] wd); step(0, 0, 0, 0, 1, wa, 13, wd); endtask
  task automatic er(); step(0, 0, 0, 1, 0, 0, 14, 0); endtask
  task automatic rq(input logic [3:0] req, input logic [127:0] pcs); step(0, req, pcs, 0, 0, 0, 12, 0); endtask
  initial begin
    @(posedge clk);
    #1;
    m_cause = 0; m_status = 32'hF; m_epc = 0;
    step(1, 0, 0, 0, 0, 0, 12, 0);
    idle(12); idle(13); idle(14); idle(3);
    chk("rst_status", status_o, 32'hF);
    rq(4'b0001, mk(32'h100, 0, 0, 0));
    chk("int_status", status_o, 32'hF0);
    chk("int_epc", epc_o, 32'hFC);
    er();
    chk("eret_status", status_o, 32'hF);
    chk("eret_epc", epc_o, 32'h0);
    rq(4'b1010, mk(0, 32'h200, 0, 32'h300));
    chk("prio_epc", epc_o, 32'h2FC);
    chk("prio_cause", cause_o, 32'hC);
    er();
    rq(4'b0001, mk(32'h100, 0, 0, 0));
    wr(13, 32'hFF);
    rq(4'b0100, mk(0, 0, 32'h400, 0));
    chk("nest_depth", {29'b0, depth_o}, 2);
    chk("nest_epc", epc_o, 32'h3FC);
    er();
    chk("nest_ret_epc", epc_o, 32'hFC);
    chk("nest_ret_status", status_o, 32'hFF);
    er(); er(); er();
    for (int i = 0; i < 4; i++) begin
      wr(13, 32'hFFFF_FFFF);
      rq(4'b1000, mk(0, 0, 0, 32'h500 + i));
    end
    wr(13, 32'hFFFF_FFFF);
    rq(4'b1000, mk(0, 0, 0, 32'h600));
    chk("ovf_set", {31'b0, overflow_o}, 1);
    chk("ovf_depth", {29'b0, depth_o}, 4);
    wr(12, 0);
    chk("ovf_clr", {31'b0, overflow_o}, 0);
    er(); er(); er();
    wr(13, 32'hFFFF_FFFF);
    step(0, 4'b0001, mk(32'h700, 0, 0, 0), 1, 0, 0, 13, 0);
    chk("eret_vs_acc", {29'b0, depth_o}, 2);
    wr(13, 32'hFFFF_FFFF);
    rq(4'b0010, mk(0, 32'h800, 0, 0));
    step(1, 0, 0, 0, 0, 0, 13, 0);
    chk("mid_rst_depth", {29'b0, depth_o}, 0);
    chk("mid_rst_status", status_o, 32'hF);
    for (int i = 0; i < 2000; i++) begin
      logic [4:0] wa;
      case ($urandom_range(0, 3))
        0: wa = 5'd12;
        1: wa = 5'd13;
        2: wa = 5'd14;
        default: wa = 5'($urandom);
      endcase
      step($urandom_range(0, 99) == 0,
           ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
           {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0,
           wa, 5'($urandom_range(11, 15)),
           ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
